// File: rtl/pilha_parametrizada_if.sv
// rtl/pilha_parametrizada_if.sv - operation/data bundle between UC/ULA and the operand stack
interface pilha_parametrizada_if #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 8
);
  localparam int PTR_W = $clog2(DEPTH) + 1;

  logic [2:0]        op;
  logic [DATA_W-1:0] din_UC;
  logic [DATA_W-1:0] din_ULA;
  logic [DATA_W-1:0] dout;
  logic [DATA_W-1:0] dout2;
  logic [PTR_W-1:0]  indice;
  logic              vazia;
  logic              cheia;
  logic              erro;

  modport master (
    output op, din_UC, din_ULA,
    input  dout, dout2, indice, vazia, cheia, erro
  );

  modport slave (
    input  op, din_UC, din_ULA,
    output dout, dout2, indice, vazia, cheia, erro
  );
endinterface

// File: rtl/pilha_parametrizada.sv
// rtl/pilha_parametrizada.sv - parametrised LIFO operand stack with ALU writeback, DUP, SWAP and CLEAR
module pilha_parametrizada #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 8
) (
  input  logic                  clock,
  input  logic                  reset,
  pilha_parametrizada_if.slave  bus
);
  localparam int PTR_W = $clog2(DEPTH) + 1;
  localparam int AW    = $clog2(DEPTH);

  localparam logic [2:0] OP_NOP      = 3'b000;
  localparam logic [2:0] OP_PUSH_UC  = 3'b001;
  localparam logic [2:0] OP_PUSH_ULA = 3'b010;
  localparam logic [2:0] OP_POP      = 3'b011;
  localparam logic [2:0] OP_POP2     = 3'b100;
  localparam logic [2:0] OP_DUP      = 3'b101;
  localparam logic [2:0] OP_SWAP     = 3'b110;
  localparam logic [2:0] OP_CLEAR    = 3'b111;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  indice_q;
  logic              erro_q;

  logic [AW-1:0]     top_a;
  logic [AW-1:0]     sec_a;
  logic [AW-1:0]     push_a;
  logic              vazia_w;
  logic              cheia_w;
  logic              ge2;

  logic              legal;
  logic              clr;
  logic              wr_en;
  logic              do_swap;
  logic [AW-1:0]     wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic [PTR_W-1:0]  indice_nxt;

  // Pointer arithmetic is only used for addressing when the op is legal,
  // so truncation/underflow of the address copies is harmless.
  assign top_a   = AW'(indice_q - PTR_W'(1));
  assign sec_a   = AW'(indice_q - PTR_W'(2));
  assign push_a  = AW'(indice_q);
  assign vazia_w = (indice_q == '0);
  assign cheia_w = (indice_q == PTR_W'(DEPTH));
  assign ge2     = (indice_q >= PTR_W'(2));

  always_comb begin
    legal      = 1'b1;
    clr        = 1'b0;
    wr_en      = 1'b0;
    do_swap    = 1'b0;
    wr_addr    = push_a;
    wr_data    = bus.din_UC;
    indice_nxt = indice_q;
    case (bus.op)
      OP_NOP: ;
      OP_PUSH_UC: begin
        if (!cheia_w) begin
          wr_en      = 1'b1;
          indice_nxt = indice_q + PTR_W'(1);
        end else legal = 1'b0;
      end
      OP_PUSH_ULA: begin
        wr_data = bus.din_ULA;
        if (!cheia_w) begin
          wr_en      = 1'b1;
          indice_nxt = indice_q + PTR_W'(1);
        end else legal = 1'b0;
      end
      OP_POP: begin
        if (!vazia_w) indice_nxt = indice_q - PTR_W'(1);
        else legal = 1'b0;
      end
      OP_POP2: begin
        wr_addr = sec_a;
        wr_data = bus.din_ULA;
        if (ge2) begin
          wr_en      = 1'b1;
          indice_nxt = indice_q - PTR_W'(1);
        end else legal = 1'b0;
      end
      OP_DUP: begin
        wr_data = mem[top_a];
        if (!vazia_w && !cheia_w) begin
          wr_en      = 1'b1;
          indice_nxt = indice_q + PTR_W'(1);
        end else legal = 1'b0;
      end
      OP_SWAP: begin
        if (ge2) do_swap = 1'b1;
        else legal = 1'b0;
      end
      OP_CLEAR: begin
        clr        = 1'b1;
        indice_nxt = '0;
      end
      default: ;
    endcase
  end

  // Storage is deliberately not reset; an op sampled while reset is high is dropped.
  always_ff @(posedge clock) begin
    if (!reset) begin
      if (do_swap) begin
        mem[top_a] <= mem[sec_a];
        mem[sec_a] <= mem[top_a];
      end else if (wr_en) begin
        mem[wr_addr] <= wr_data;
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      indice_q <= '0;
      erro_q   <= 1'b0;
    end else begin
      indice_q <= indice_nxt;
      if (clr)         erro_q <= 1'b0;
      else if (!legal) erro_q <= 1'b1;
    end
  end

  assign bus.dout   = vazia_w ? '0 : mem[top_a];
  assign bus.dout2  = ge2 ? mem[sec_a] : '0;
  assign bus.indice = indice_q;
  assign bus.vazia  = vazia_w;
  assign bus.cheia  = cheia_w;
  assign bus.erro   = erro_q;
endmodule

// File: tb/tb_pilha_parametrizada.sv
// tb/tb_pilha_parametrizada.sv - directed self-checking bench for pilha_parametrizada
module tb_pilha_parametrizada;
  localparam logic [2:0] NOP = 3'b000, PUSH_UC = 3'b001, PUSH_ULA = 3'b010, POP = 3'b011;
  localparam logic [2:0] POP2 = 3'b100, DUP = 3'b101, SWAP = 3'b110, CLEAR = 3'b111;

  logic clock = 1'b0;
  logic reset = 1'b1;
  int   vectors = 0;
  int   miscompares = 0;

  pilha_parametrizada_if #(.DATA_W(8), .DEPTH(4)) bus();

  pilha_parametrizada #(.DATA_W(8), .DEPTH(4)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic [2:0] o, input logic [7:0] uc, input logic [7:0] ula);
    @(negedge clock);
    bus.op      = o;
    bus.din_UC  = uc;
    bus.din_ULA = ula;
    @(posedge clock);
    #1;
    bus.op = NOP;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    bus.op = NOP; bus.din_UC = '0; bus.din_ULA = '0;
    #3;
    check("rst_indice", bus.indice, 0);
    check("rst_erro",   bus.erro, 0);
    check("rst_vazia",  bus.vazia, 1);
    check("rst_cheia",  bus.cheia, 0);
    check("rst_dout",   bus.dout, 0);
    check("rst_dout2",  bus.dout2, 0);
    @(negedge clock);
    reset = 1'b0;

    step(PUSH_UC, 8'd5, 8'd0);
    step(PUSH_UC, 8'd3, 8'd0);
    check("p1_dout",   bus.dout, 3);
    check("p1_dout2",  bus.dout2, 5);
    check("p1_indice", bus.indice, 2);
    check("p1_vazia",  bus.vazia, 0);
    check("p1_erro",   bus.erro, 0);

    step(POP2, 8'd0, 8'd8);
    check("p2_dout",   bus.dout, 8);
    check("p2_dout2",  bus.dout2, 0);
    check("p2_indice", bus.indice, 1);
    step(POP, 8'd0, 8'd0);
    check("p2_pop_indice", bus.indice, 0);
    check("p2_pop_vazia",  bus.vazia, 1);
    check("p2_pop_dout",   bus.dout, 0);

    step(PUSH_UC, 8'd1, 8'd0);
    step(PUSH_UC, 8'd2, 8'd0);
    step(PUSH_UC, 8'd3, 8'd0);
    step(PUSH_UC, 8'd4, 8'd0);
    check("p3_cheia",  bus.cheia, 1);
    check("p3_dout2",  bus.dout2, 3);
    step(PUSH_UC, 8'd9, 8'd0);
    check("p3_ovf_indice", bus.indice, 4);
    check("p3_ovf_dout",   bus.dout, 4);
    check("p3_ovf_erro",   bus.erro, 1);
    step(DUP, 8'd0, 8'd0);
    check("p3_dup_indice", bus.indice, 4);
    check("p3_dup_erro",   bus.erro, 1);
    check("p3_dup_dout",   bus.dout, 4);

    step(CLEAR, 8'd0, 8'd0);
    check("p4_clr_indice", bus.indice, 0);
    check("p4_clr_erro",   bus.erro, 0);
    check("p4_clr_vazia",  bus.vazia, 1);
    step(POP, 8'd0, 8'd0);
    check("p4_udf_indice", bus.indice, 0);
    check("p4_udf_erro",   bus.erro, 1);
    step(CLEAR, 8'd0, 8'd0);
    step(PUSH_UC, 8'd7, 8'd0);
    check("p4_one_erro", bus.erro, 0);
    step(SWAP, 8'd0, 8'd0);
    check("p4_swap_erro",   bus.erro, 1);
    check("p4_swap_dout",   bus.dout, 7);
    check("p4_swap_indice", bus.indice, 1);
    step(CLEAR, 8'd0, 8'd0);
    step(PUSH_UC, 8'd7, 8'd0);
    step(POP2, 8'd0, 8'h55);
    check("p4_pop2_erro",   bus.erro, 1);
    check("p4_pop2_dout",   bus.dout, 7);
    check("p4_pop2_indice", bus.indice, 1);

    step(CLEAR, 8'd0, 8'd0);
    step(PUSH_UC, 8'd1, 8'd0);
    step(PUSH_UC, 8'd2, 8'd0);
    step(SWAP, 8'd0, 8'd0);
    check("p5_swap_dout",  bus.dout, 1);
    check("p5_swap_dout2", bus.dout2, 2);
    check("p5_swap_erro",  bus.erro, 0);
    step(DUP, 8'd0, 8'd0);
    check("p5_dup_indice", bus.indice, 3);
    check("p5_dup_dout",   bus.dout, 1);
    check("p5_dup_dout2",  bus.dout2, 1);
    step(PUSH_ULA, 8'd0, 8'hAA);
    check("p5_ula_dout",   bus.dout, 8'hAA);
    check("p5_ula_indice", bus.indice, 4);
    check("p5_ula_cheia",  bus.cheia, 1);
    step(NOP, 8'd0, 8'd0);
    check("p5_nop_dout",   bus.dout, 8'hAA);
    check("p5_nop_indice", bus.indice, 4);

    step(PUSH_UC, 8'h11, 8'd0);
    step(POP, 8'd0, 8'd0);
    check("p6_pre_indice", bus.indice, 3);
    check("p6_pre_erro",   bus.erro, 1);
    check("p6_pre_dout",   bus.dout, 1);
    @(negedge clock);
    bus.op     = PUSH_UC;
    bus.din_UC = 8'h77;
    reset      = 1'b1;
    #1;
    check("p6_async_indice", bus.indice, 0);
    check("p6_async_erro",   bus.erro, 0);
    check("p6_async_dout",   bus.dout, 0);
    check("p6_async_vazia",  bus.vazia, 1);
    @(posedge clock);
    #1;
    check("p6_held_indice", bus.indice, 0);
    @(negedge clock);
    reset  = 1'b0;
    bus.op = NOP;
    @(posedge clock);
    #1;
    check("p6_post_indice", bus.indice, 0);
    check("p6_post_dout",   bus.dout, 0);
    step(PUSH_UC, 8'h42, 8'd0);
    check("p6_push_dout",   bus.dout, 8'h42);
    check("p6_push_indice", bus.indice, 1);
    check("p6_push_dout2",  bus.dout2, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/pilha_parametrizada.md
Name: pilha_parametrizada

Overview:
Parametrised successor to the processor's fixed operand stack. It holds DATA_W-bit words in a DEPTH-entry LIFO and adds stack-machine ops the control unit otherwise builds from several cycles: replace-two-with-result (ALU writeback), DUP, SWAP and CLEAR. It also exposes top and second-of-stack to the ALU operand path and raises a sticky error flag on overflow or underflow. It sits in the datapath between the UC (immediate pushes) and the ULA (results and operands).

Parameters:
DATA_W, 8, word width of stack entries and data ports.
DEPTH, 8, number of entries; power of two, >= 2.
(derived, not overridable) PTR_W = clog2(DEPTH)+1, so indice can represent 0..DEPTH.

Ports:
clock  in  1  system clock, rising edge.
reset  in  1  asynchronous, active-high; clears indice and erro.
op  in  3  operation: 000 NOP, 001 PUSH_UC, 010 PUSH_ULA, 011 POP, 100 POP2_PUSH_ULA, 101 DUP, 110 SWAP, 111 CLEAR.
din_UC  in  DATA_W  immediate from control unit (PUSH_UC).
din_ULA  in  DATA_W  ALU result (PUSH_ULA, POP2_PUSH_ULA).
dout  out  DATA_W  top of stack; 0 when indice==0.
dout2  out  DATA_W  second entry (below top); 0 when indice<2.
indice  out  PTR_W  current occupancy, 0..DEPTH.
vazia  out  1  indice==0.
cheia  out  1  indice==DEPTH.
erro  out  1  sticky illegal-op flag.

Behaviour:
- Storage: DEPTH x DATA_W register array, not reset. Only indice and erro are reset. Entry k (0-based) is valid iff k < indice; the top is entry indice-1.
- Reset (async): indice=0, erro=0 immediately. Therefore dout=0, dout2=0, vazia=1, cheia=0 with no clock. Reset asserted mid-operation discards the op in flight.
- All ops are sampled on the rising clock edge. Effects are visible on the outputs right after that edge (1-cycle latency). dout, dout2, vazia and cheia are combinational from indice and the array.
- PUSH_UC / PUSH_ULA: legal if indice<DEPTH. Writes the input to entry indice, then indice+1.
- POP: legal if indice>=1; indice-1. Data is not cleared.
- POP2_PUSH_ULA: legal if indice>=2. Writes din_ULA to entry indice-2, then indice-1 (net -1).
- DUP: legal if 1<=indice<DEPTH. Copies entry indice-1 to entry indice, then indice+1.
- SWAP: legal if indice>=2. Exchanges entries indice-1 and indice-2 in one edge; indice unchanged.
- CLEAR: indice=0, erro=0. Always legal.
- NOP: no change.
- Illegal op (any legality condition false): array and indice unchanged; erro set to 1 on that edge.
- erro stays 1 until CLEAR or reset. Legal ops do not clear it.
- No wrap-around: indice saturates at 0 and DEPTH through the illegal-op rule. The pointer never aliases.
- op values are decoded fully; there are no undefined encodings.

Test Plan:
1. DATA_W=8, DEPTH=4. Reset, then PUSH_UC 5, then PUSH_UC 3 -> dout=3, dout2=5, indice=2, vazia=0, erro=0.
2. From 1: POP2_PUSH_ULA with din_ULA=8 -> dout=8, dout2=0, indice=1. Then POP -> indice=0, vazia=1, dout=0.
3. PUSH_UC 1, 2, 3, 4 -> cheia=1. PUSH_UC 9 -> indice=4, dout=4, erro=1. DUP -> still indice=4, erro=1.
4. CLEAR -> indice=0, erro=0, vazia=1. POP -> indice=0, erro=1. SWAP and POP2_PUSH_ULA with indice=1 -> erro=1, dout unchanged.
5. From empty: PUSH_UC 1, PUSH_UC 2, SWAP -> dout=1, dout2=2. DUP -> indice=3, dout=1, dout2=1. PUSH_ULA 0xAA -> dout=0xAA, indice=4.
6. With indice=3 and erro=1, pulse reset between clock edges -> indice=0, erro=0, dout=0 before the next edge. A PUSH_UC presented during reset is ignored.
